uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter, next generation of the single-byte RS232 sender.
- Adds configurable frame format (data bits, parity, stop bits) and a valid/ready input handshake.
- Adds an internal FIFO so producers (sensor/distance formatters) can queue several words.
- Frames go out back-to-back on a single tx line to the STM32.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s; DIV = CLK_FREQ/BAUD (integer truncation), must be >= 2
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, FIFO entries, power of two, >= 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
s_data  in  DATA_BITS  word to send, LSB transmitted first
s_valid  in  1  s_data valid
s_ready  out  1  FIFO can accept; equals !full
tx  out  1  serial line, idles high, registered
busy  out  1  high while a frame is on the line (state != IDLE)
tx_done  out  1  one-cycle pulse on the last cycle of the final stop bit
fifo_count  out  clog2(FIFO_DEPTH+1)  entries currently queued

Behaviour:
- Reset (rst high at a clk edge):
  - tx=1, busy=0, tx_done=0, fifo_count=0, s_ready=1.
  - State IDLE, baud and bit counters 0, FIFO flushed.
- Reset asserted mid-frame: frame is abandoned; tx is high after that edge. No tx_done for the aborted frame.
- Handshake:
  - A word is written on any edge where s_valid && s_ready.
  - s_ready = !full, combinational from the FIFO count.
  - When full, a push is refused even if a pop occurs on the same edge.
  - Simultaneous push and pop when not full: fifo_count unchanged.
  - A push into an empty FIFO and a pop cannot occur on the same edge; the pop happens at the earliest one cycle later.
- Baud timing:
  - Counter runs 0..DIV-1; every line bit is held exactly DIV clk cycles.
  - Counter width is clog2(DIV).
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: if fifo_count != 0, pop head into the shift register, tx<=0, go to START. Otherwise tx=1.
  - START: after DIV cycles, tx<=data[0], go to DATA.
  - DATA: shift one bit per DIV cycles. After DATA_BITS bits, go to PAR if PARITY != 0, else STOP.
  - PAR: tx = XOR of the data bits (even), or its inverse (odd), for DIV cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS*DIV cycles. tx_done=1 in the final cycle.
    - If the FIFO is non-empty, pop on that edge and go straight to START (tx<=0); no idle gap between frames.
    - Else go to IDLE.
- Latency: word pushed into an empty idle FIFO at edge k -> tx low after edge k+1.
- Frame length in clk cycles: DIV*(1 + DATA_BITS + (PARITY!=0) + STOP_BITS).
- s_data bits above DATA_BITS do not exist. Changes to s_data after acceptance do not affect the queued word.
- Illegal parameters (DIV<2, DATA_BITS outside 5..9, PARITY>2, STOP_BITS not 1/2, FIFO_DEPTH not a power of two) cause an elaboration-time error.

Test Plan:
- Sim params CLK_FREQ=1600, BAUD=100 (DIV=16), 8N1. Push 0xA5 once.
  - tx low 1 cycle after acceptance.
  - Bits 1,0,1,0,0,1,0,1 then stop, each 16 cycles.
  - tx_done pulses at cycle 160 of the frame; busy drops next cycle.
- 8E1, push 0x07 (three ones) -> parity bit 1; frame 176 cycles. Repeat with PARITY=1 -> parity bit 0.
- DATA_BITS=7, PARITY=1, STOP_BITS=2, push 0x55 -> 7 data bits 1010101, parity 1, tx high 32 cycles; frame 176 cycles.
- FIFO_DEPTH=4, s_valid held high with 0x01..0x06:
  - first word popped; next four fill the FIFO; s_ready=0, fifo_count=4.
  - 0x06 is accepted only after the next pop.
  - All six frames are back-to-back with no high gap beyond the stop bits.
- Reset mid-frame (assert at data bit 3 with 2 words queued) -> tx=1, fifo_count=0, busy=0 after the edge. No tx_done. Next push produces a clean frame.
- Push and pop on the same edge with fifo_count=2 -> count stays 2. Push while full with a concurrent pop -> refused (s_ready=0); count drops to 3.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small word FIFO through a valid/ready port.
// Frames are start, LSB-first data, optional parity and 1-2 stop bits, sent back-to-back.
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [DATA_BITS-1:0]                  s_data,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    output logic                                  tx,
    output logic                                  busy,
    output logic                                  tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count
);

    localparam int unsigned DIV     = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned AW      = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BIT_W   = 4;
    localparam logic        PAR_ODD = (PARITY == 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: CLK_FREQ/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be in 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 push, pop;
    logic [DATA_BITS-1:0] head;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 busy_q;
    logic                 baud_end, last_stop;

    assign s_ready    = (count_q != CW'(FIFO_DEPTH));
    assign push       = s_valid && s_ready;
    assign head       = mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;

    // FIFO storage; pointer reset is enough to flush it
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign baud_end  = (baud_q == CNT_W'(DIV - 1));
    assign last_stop = (bit_q == BIT_W'(STOP_BITS - 1));

    // Frame sequencer; pop comes from the registered count, so a fresh push waits a cycle
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                bit_d  = '0;
                pop    = (count_q != '0);
            end
            START: begin
                baud_d = baud_q + CNT_W'(1);
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = DATA;
                end
            end
            DATA: begin
                baud_d = baud_q + CNT_W'(1);
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            tx_d    = par_q;
                            state_d = PAR;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PAR: begin
                baud_d = baud_q + CNT_W'(1);
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                baud_d = baud_q + CNT_W'(1);
                if (last_stop && baud_q == CNT_W'(DIV - 2)) begin
                    done_d = 1'b1;
                end
                if (baud_end) begin
                    baud_d = '0;
                    if (last_stop) begin
                        bit_d   = '0;
                        tx_d    = 1'b1;
                        state_d = IDLE;
                        pop     = (count_q != '0);
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Loading the next word overrides the idle/stop exit so frames abut
        if (pop) begin
            shift_d = head;
            par_d   = (^head) ^ PAR_ODD;
            tx_d    = 1'b0;
            baud_d  = '0;
            bit_d   = '0;
            state_d = START;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= (state_d != IDLE);
        end
    end

endmodule
